// File: rtl/score_display_pkg.sv
// Shared constants and types for the score display scanner.
package score_display_pkg;

    localparam int unsigned NUM_SCAN_DIGITS = 3;
    localparam int unsigned BCD_W           = 4;
    localparam int unsigned SEG_W           = 7;
    localparam int unsigned AN_W            = 4;

    // Index of the digit being scanned: 0 = ones, 1 = tens, 2 = hundreds.
    typedef logic [1:0] digit_sel_t;

    // Snapshot of the three score digits held for one refresh frame.
    typedef struct packed {
        logic [BCD_W-1:0] hundreds;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } score_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    localparam logic [AN_W-1:0] AN_OFF = 4'b1111;

    // Active-low one-cold anode select for a scanned digit.
    function automatic logic [AN_W-1:0] anode_sel(input digit_sel_t d);
        return ~(AN_W'(1) << d);
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Score-digit inputs and display-driver outputs between score logic and scanner.
interface score_display_if;
    import score_display_pkg::*;

    logic             enable;
    logic             blank_lz;
    logic             blink;
    logic [BCD_W-1:0] hundreds_digit;
    logic [BCD_W-1:0] tens_digit;
    logic [BCD_W-1:0] ones_digit;
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
    logic             dp;
    logic             frame_tick;

    // Score producer / board side.
    modport master (
        output enable, blank_lz, blink,
        output hundreds_digit, tens_digit, ones_digit,
        input  an, seg, dp, frame_tick
    );

    // Display scanner side.
    modport slave (
        input  enable, blank_lz, blink,
        input  hundreds_digit, tens_digit, ones_digit,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/score_display_scanner_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
    import score_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    // Table lookup with dash for invalid BCD.
    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_DIGIT[0];
            4'd1:    seg_c = SEG_DIGIT[1];
            4'd2:    seg_c = SEG_DIGIT[2];
            4'd3:    seg_c = SEG_DIGIT[3];
            4'd4:    seg_c = SEG_DIGIT[4];
            4'd5:    seg_c = SEG_DIGIT[5];
            4'd6:    seg_c = SEG_DIGIT[6];
            4'd7:    seg_c = SEG_DIGIT[7];
            4'd8:    seg_c = SEG_DIGIT[8];
            4'd9:    seg_c = SEG_DIGIT[9];
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_scanner.sv
// Multiplexed 3-digit common-anode 7-segment driver with per-frame snapshot,
// leading-zero blanking, invalid-BCD dash and blink.
module score_display_scanner
    import score_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic          clk,
    input  logic          rst,
    score_display_if.slave bus
);

    localparam int unsigned DIV_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam digit_sel_t       SEL_LAST = digit_sel_t'(NUM_SCAN_DIGITS - 1);

    // State registers
    logic [DIV_W-1:0] div_cnt,      div_cnt_nxt;
    digit_sel_t       digit_sel,    digit_sel_nxt;
    score_t           shadow,       shadow_nxt;
    logic             shadow_valid, shadow_valid_nxt;
    logic [BLK_W-1:0] blink_cnt,    blink_cnt_nxt;
    logic             blink_phase,  blink_phase_nxt;

    // Output registers
    logic [AN_W-1:0]  an_q,         an_nxt;
    logic [SEG_W-1:0] seg_q,        seg_nxt;
    logic             frame_tick_q, frame_tick_nxt;

    // Combinational helpers
    logic             div_terminal;
    logic             frame_wrap;
    score_t           score_in;
    logic [BCD_W-1:0] digit_mux;
    logic             digit_hidden;
    logic             dark;
    logic [SEG_W-1:0] seg_dec;

    assign score_in = {bus.hundreds_digit, bus.tens_digit, bus.ones_digit};

    // Scan divider, digit select, frame snapshot and blink phase next-state.
    always_comb begin
        div_terminal     = (div_cnt == DIV_LAST);
        frame_wrap       = div_terminal && (digit_sel == SEL_LAST);
        div_cnt_nxt      = div_terminal ? '0 : div_cnt + DIV_W'(1);
        digit_sel_nxt    = digit_sel;
        shadow_nxt       = shadow;
        shadow_valid_nxt = shadow_valid;
        blink_cnt_nxt    = blink_cnt;
        blink_phase_nxt  = blink_phase;
        frame_tick_nxt   = frame_wrap;

        if (div_terminal) begin
            digit_sel_nxt = (digit_sel == SEL_LAST) ? '0 : digit_sel + digit_sel_t'(1);
        end

        // Latch a whole frame's worth of digits at once so a score update never tears.
        if (frame_wrap) begin
            shadow_nxt       = score_in;
            shadow_valid_nxt = 1'b1;
        end

        if (!bus.blink) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b1;
        end else if (frame_wrap) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt   = blink_cnt + BLK_W'(1);
            end
        end
    end

    // Select the scanned shadow digit and decide whether it is blanked.
    always_comb begin
        digit_mux    = shadow.ones;
        digit_hidden = 1'b0;
        case (digit_sel)
            2'd0: begin
                digit_mux    = shadow.ones;
                digit_hidden = 1'b0;
            end
            2'd1: begin
                digit_mux    = shadow.tens;
                digit_hidden = bus.blank_lz && (shadow.hundreds == '0) && (shadow.tens == '0);
            end
            default: begin
                digit_mux    = shadow.hundreds;
                digit_hidden = bus.blank_lz && (shadow.hundreds == '0);
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd   (digit_mux),
        .seg_c (seg_dec)
    );

    // Drive anode/segment next values; live blink input lets a dropped blink show at once.
    always_comb begin
        dark = !bus.enable
            || (bus.blink && !blink_phase)
            || digit_hidden
            || !shadow_valid
            || (digit_sel > SEL_LAST);
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
        if (!dark) begin
            an_nxt  = anode_sel(digit_sel);
            seg_nxt = seg_dec;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            digit_sel    <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt      <= div_cnt_nxt;
            digit_sel    <= digit_sel_nxt;
            shadow       <= shadow_nxt;
            shadow_valid <= shadow_valid_nxt;
            blink_cnt    <= blink_cnt_nxt;
            blink_phase  <= blink_phase_nxt;
            an_q         <= an_nxt;
            seg_q        <= seg_nxt;
            frame_tick_q <= frame_tick_nxt;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/score_display_scanner.md
Name: score_display_scanner

Overview:
- Consumer end of the score interface: takes the three BCD score digits and drives the board's 4-digit, common-anode, multiplexed 7-segment display.
- Time-multiplexes hundreds/tens/ones onto anodes 2..0; anode 3 is always off.
- Snapshots the digits once per refresh frame so an increment never tears a frame.
- Adds leading-zero blanking, invalid-BCD indication and a blink mode for end-of-game.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is lit (>=2).
- BLINK_FRAMES, 64, frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  1 = display on; 0 = all digits dark
- blank_lz  in  1  1 = suppress leading zeros
- blink  in  1  1 = flash display on/off
- hundreds_digit  in  4  BCD 100's
- tens_digit  in  4  BCD 10's
- ones_digit  in  4  BCD 1's
- an  out  4  anode selects, active-low, an[0] = ones
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low, always 1 (off)
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (rst=1 at a clk edge):
  - div_cnt=0, digit_sel=0, shadow digits=0, blink_cnt=0, blink_phase=1 (visible).
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
  - Reset mid-frame aborts the scan immediately.
- Divider and digit select:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, digit_sel advances 0->1->2->0, giving a frame of 3*REFRESH_DIV cycles.
- Snapshot:
  - Shadow registers load all three inputs when digit_sel wraps 2->0.
  - frame_tick pulses high in that same cycle.
  - Input changes mid-frame are not visible until the next frame.
- Blink:
  - blink_cnt counts frames 0..BLINK_FRAMES-1; at wrap, blink_phase toggles.
  - While blink=0, blink_cnt is held at 0 and blink_phase at 1.
  - On the cycle blink falls, blink_phase returns to 1.
- Digit visibility (shadow values):
  - ones: always visible.
  - tens: hidden when blank_lz=1 and hundreds=0 and tens=0.
  - hundreds: hidden when blank_lz=1 and hundreds=0.
- Output registration:
  - an/seg are registered, one cycle after digit_sel/div_cnt state.
  - Selected digit d: an = ~(4'b0001<<d) and seg = decode(shadow[d]).
  - Override: if enable=0, or blink_phase=0, or digit d is hidden, then an=4'b1111 and seg=7'b1111111.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash 0111111
- enable=0:
  - The divider and snapshot keep running; only the outputs are forced dark.
  - Re-enabling resumes at the current digit_sel with no restart.
- Anodes: exactly zero or one an bit is low in any cycle; an[3] is always 1.

Decomposition:
- Package score_display_pkg holds:
  - SEG_BLANK, SEG_DASH and the SEG_DIGIT[0:9] constants.
  - NUM_SCAN_DIGITS=3.
  - A digit_sel_t typedef (2-bit).
- Sub-module bcd_to_seg7: combinational 4-bit BCD to 7-bit active-low pattern, dash for >9.
- Instantiated once on the muxed shadow digit.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset release, inputs 1/2/3, blank_lz=0:
  - Outputs stay dark until the first frame_tick.
  - After the first frame_tick, the bench must see an 1110/seg 0110000, then 1101/0100100, then 1011/1111001, each held 4 cycles.
  - The period repeats every 12 cycles.
- Inputs 0/0/7, blank_lz=1: only an=1110 with seg=1111000; the tens and hundreds slots output 1111/1111111. Repeat with 0/5/0: the tens slot shows 0010010, the ones slot 1000000.
- Tearing: change inputs 1/2/3 -> 4/5/6 mid-frame; the current frame still shows 1,2,3, and 4,5,6 appear only after the next frame_tick.
- Invalid BCD: ones=4'hC shows seg=0111111. With enable=0, an=1111 and seg=1111111 every cycle, and frame_tick still pulses every 12 cycles.
- Blink=1: the display is visible for 2 frames (24 cycles), dark for 2 frames, and so on. Dropping blink restores a visible display on the next registered output.
- Assert rst for one cycle mid-scan: the next output is an=1111, and digit_sel restarts at 0 with 0/0/0 shadows.
